// File: rtl/id_ex_stage_reg.sv
// -----------------------------------------------------------------------------
// id_ex_stage_reg
//
// ID/EX pipeline register sitting directly behind the main control decoder.
// Captures decoder control bits together with the ID-stage operands and
// presents them, registered, to the EX stage. Supports squash (flush_i),
// hold (stall_i) and, when compiled in, load-use hazard detection, which
// inserts a single control bubble and asks upstream to hold PC and IF/ID.
//
// Build option:
//   IDEX_HAZARD_DETECT_EN  defined   -> load-use detector present,
//                                       hazard_stall_o driven.
//                          undefined -> detector removed, hazard_stall_o = 0;
//                                       upstream must avoid load-use pairs.
//
// Parameters:
//   XLEN  datapath width of PC, register data and immediate
//   RIDX  register index width
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   valid_i             ID holds a real instruction
//   stall_i             EX busy: hold all ID/EX contents
//   flush_i             taken branch/jump: squash the ID instruction
//   branch_i .. jump_i  decoder control bits; aluop_i ALU op class
//   pc_i, rs1_data_i, rs2_data_i, imm_i   ID-stage operands
//   rs1_i, rs2_i, rd_i  register indices; funct3_i, funct7b5_i funct bits
//   ex_*                registered copies of the matching inputs
//   hazard_stall_o      combinational: hold PC and IF/ID this cycle
// -----------------------------------------------------------------------------
module id_ex_stage_reg #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RIDX = 5
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            valid_i,
    input  logic            stall_i,
    input  logic            flush_i,

    input  logic            branch_i,
    input  logic            memread_i,
    input  logic            memtoreg_i,
    input  logic            memwrite_i,
    input  logic            alusrc_i,
    input  logic            regwrite_i,
    input  logic            jump_i,
    input  logic [1:0]      aluop_i,

    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [RIDX-1:0] rs1_i,
    input  logic [RIDX-1:0] rs2_i,
    input  logic [RIDX-1:0] rd_i,
    input  logic [2:0]      funct3_i,
    input  logic            funct7b5_i,

    output logic            ex_valid,
    output logic            ex_branch,
    output logic            ex_memread,
    output logic            ex_memtoreg,
    output logic            ex_memwrite,
    output logic            ex_alusrc,
    output logic            ex_regwrite,
    output logic            ex_jump,
    output logic [1:0]      ex_aluop,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [RIDX-1:0] ex_rs1,
    output logic [RIDX-1:0] ex_rs2,
    output logic [RIDX-1:0] ex_rd,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7b5,

    output logic            hazard_stall_o
);

    // Whole stage held as one record so bubble/hold/load are single assignments.
    typedef struct packed {
        logic            valid;
        logic            branch;
        logic            memread;
        logic            memtoreg;
        logic            memwrite;
        logic            alusrc;
        logic            regwrite;
        logic            jump;
        logic [1:0]      aluop;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [RIDX-1:0] rs1;
        logic [RIDX-1:0] rs2;
        logic [RIDX-1:0] rd;
        logic [2:0]      funct3;
        logic            funct7b5;
    } idex_t;

    idex_t stage_q;
    idex_t stage_d;
    idex_t id_word;
    logic  load_use;

    // Gather the ID-side inputs into the stage record.
    always_comb begin
        id_word          = '0;
        id_word.valid    = valid_i;
        id_word.branch   = branch_i;
        id_word.memread  = memread_i;
        id_word.memtoreg = memtoreg_i;
        id_word.memwrite = memwrite_i;
        id_word.alusrc   = alusrc_i;
        id_word.regwrite = regwrite_i;
        id_word.jump     = jump_i;
        id_word.aluop    = aluop_i;
        id_word.pc       = pc_i;
        id_word.rs1_data = rs1_data_i;
        id_word.rs2_data = rs2_data_i;
        id_word.imm      = imm_i;
        id_word.rs1      = rs1_i;
        id_word.rs2      = rs2_i;
        id_word.rd       = rd_i;
        id_word.funct3   = funct3_i;
        id_word.funct7b5 = funct7b5_i;
    end

`ifdef IDEX_HAZARD_DETECT_EN
    // Load in EX whose destination feeds the ID instruction. rd = x0 is never
    // a real dependency. rs2 is compared even when the ID instruction has no
    // rs2 operand; the occasional extra bubble is cheaper than decoding format.
    always_comb begin
        load_use = stage_q.valid & stage_q.memread & (stage_q.rd != '0) & valid_i &
                   ((stage_q.rd == rs1_i) | (stage_q.rd == rs2_i));
    end

    // A flush kills the dependent instruction and a stall already freezes the
    // front end, so neither needs an extra hold request.
    assign hazard_stall_o = load_use & ~flush_i & ~stall_i;
`else
    assign load_use       = 1'b0;
    assign hazard_stall_o = 1'b0;
`endif

    // Per-edge priority: flush, stall, load-use, invalid ID, normal load.
    // A bubble is all-zero, so it carries no ctrl side effects and clears
    // ex_memread, which lets the held instruction advance on the next edge.
    always_comb begin
        stage_d = stage_q;
        if (flush_i) begin
            stage_d = '0;
        end else if (stall_i) begin
            stage_d = stage_q;
        end else if (load_use) begin
            stage_d = '0;
        end else if (!valid_i) begin
            stage_d = '0;
        end else begin
            stage_d = id_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign ex_valid    = stage_q.valid;
    assign ex_branch   = stage_q.branch;
    assign ex_memread  = stage_q.memread;
    assign ex_memtoreg = stage_q.memtoreg;
    assign ex_memwrite = stage_q.memwrite;
    assign ex_alusrc   = stage_q.alusrc;
    assign ex_regwrite = stage_q.regwrite;
    assign ex_jump     = stage_q.jump;
    assign ex_aluop    = stage_q.aluop;
    assign ex_pc       = stage_q.pc;
    assign ex_rs1_data = stage_q.rs1_data;
    assign ex_rs2_data = stage_q.rs2_data;
    assign ex_imm      = stage_q.imm;
    assign ex_rs1      = stage_q.rs1;
    assign ex_rs2      = stage_q.rs2;
    assign ex_rd       = stage_q.rd;
    assign ex_funct3   = stage_q.funct3;
    assign ex_funct7b5 = stage_q.funct7b5;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
module tb_id_ex_stage_reg;

    localparam int XLEN = 32;
    localparam int RIDX = 5;
    localparam int OW   = 157;

`ifdef IDEX_HAZARD_DETECT_EN
    localparam bit HZ = 1'b1;
`else
    localparam bit HZ = 1'b0;
`endif

    // ctrl = {branch, memread, memtoreg, memwrite, alusrc, regwrite, jump, aluop[1:0]}
    localparam logic [8:0] C_ALU  = 9'b000001010;
    localparam logic [8:0] C_LW   = 9'b011011000;
    localparam logic [8:0] C_SW   = 9'b000110000;
    localparam logic [8:0] C_BR   = 9'b100000001;
    localparam logic [8:0] C_ADDI = 9'b000011010;
    localparam logic [8:0] C_JAL  = 9'b000001100;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            valid_i, stall_i, flush_i;
    logic            branch_i, memread_i, memtoreg_i, memwrite_i, alusrc_i, regwrite_i, jump_i;
    logic [1:0]      aluop_i;
    logic [XLEN-1:0] pc_i, rs1_data_i, rs2_data_i, imm_i;
    logic [RIDX-1:0] rs1_i, rs2_i, rd_i;
    logic [2:0]      funct3_i;
    logic            funct7b5_i;

    logic            ex_valid, ex_branch, ex_memread, ex_memtoreg, ex_memwrite;
    logic            ex_alusrc, ex_regwrite, ex_jump;
    logic [1:0]      ex_aluop;
    logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [RIDX-1:0] ex_rs1, ex_rs2, ex_rd;
    logic [2:0]      ex_funct3;
    logic            ex_funct7b5;
    logic            hazard_stall_o;

    id_ex_stage_reg #(.XLEN(XLEN), .RIDX(RIDX)) dut (
        .clk(clk), .rst_n(rst_n),
        .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
        .branch_i(branch_i), .memread_i(memread_i), .memtoreg_i(memtoreg_i),
        .memwrite_i(memwrite_i), .alusrc_i(alusrc_i), .regwrite_i(regwrite_i),
        .jump_i(jump_i), .aluop_i(aluop_i),
        .pc_i(pc_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
        .funct3_i(funct3_i), .funct7b5_i(funct7b5_i),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_memread(ex_memread),
        .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite), .ex_alusrc(ex_alusrc),
        .ex_regwrite(ex_regwrite), .ex_jump(ex_jump), .ex_aluop(ex_aluop),
        .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
        .hazard_stall_o(hazard_stall_o)
    );

    typedef enum logic [1:0] {K_LOAD, K_HOLD, K_BUB} kind_t;

    typedef struct {
        logic        valid, stall, flush;
        logic [8:0]  ctrl;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic        f7;
        kind_t       kind;
        logic        hz;
    } vec_t;

    vec_t            tbl[$];
    logic [OW-1:0]   exp_q[$];
    logic [OW-1:0]   model_state;
    int unsigned     total = 0;
    int unsigned     bad   = 0;

    function automatic vec_t mk(logic v, logic st, logic fl, logic [8:0] c,
                                logic [4:0] r1, logic [4:0] r2, logic [4:0] rd,
                                logic [31:0] d1, kind_t k, logic hz, int unsigned seed);
        vec_t t;
        t.valid = v;  t.stall = st; t.flush = fl; t.ctrl = c;
        t.rs1 = r1;   t.rs2 = r2;   t.rd = rd;
        t.pc   = 32'h0000_1000 + seed * 4;
        t.rs1d = d1;
        t.rs2d = ~d1 ^ seed;
        t.imm  = {seed[15:0], 16'hFFF0};
        t.f3   = seed[2:0];
        t.f7   = seed[0];
        t.kind = k;   t.hz = hz;
        return t;
    endfunction

    function automatic logic [OW-1:0] pack_vec(vec_t t);
        return {t.valid, t.ctrl, t.pc, t.rs1d, t.rs2d, t.imm, t.rs1, t.rs2, t.rd, t.f3, t.f7};
    endfunction

    function automatic logic [OW-1:0] dut_word();
        return {ex_valid, ex_branch, ex_memread, ex_memtoreg, ex_memwrite, ex_alusrc,
                ex_regwrite, ex_jump, ex_aluop, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
                ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7b5};
    endfunction

    task automatic check(string nm, logic [OW-1:0] act, logic [OW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic drive(vec_t t);
        valid_i = t.valid; stall_i = t.stall; flush_i = t.flush;
        {branch_i, memread_i, memtoreg_i, memwrite_i, alusrc_i, regwrite_i, jump_i, aluop_i} = t.ctrl;
        pc_i = t.pc; rs1_data_i = t.rs1d; rs2_data_i = t.rs2d; imm_i = t.imm;
        rs1_i = t.rs1; rs2_i = t.rs2; rd_i = t.rd;
        funct3_i = t.f3; funct7b5_i = t.f7;
    endtask

    // Drive at negedge, check the combinational stall request, queue the
    // expected post-edge contents, then compare just after the rising edge.
    task automatic step(vec_t t, string nm);
        logic [OW-1:0] e;
        @(negedge clk);
        drive(t);
        #1;
        check({nm, "_hz"}, OW'(hazard_stall_o), OW'(t.hz));
        case (t.kind)
            K_BUB:   e = '0;
            K_HOLD:  e = model_state;
            default: e = pack_vec(t);
        endcase
        model_state = e;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({nm, "_sb_empty"}, OW'(1), OW'(0));
        end else begin
            check({nm, "_out"}, dut_word(), exp_q.pop_front());
        end
    endtask

    initial begin
        vec_t idle;
        idle = mk(0, 0, 0, '0, 0, 0, 0, '0, K_BUB, 0, 0);
        idle.pc = '0; idle.rs2d = '0; idle.imm = '0;
        rst_n = 1'b0;
        drive(idle);
        model_state = '0;

        //           v  st fl ctrl    rs1 rs2 rd  rs1_data       kind                hz  seed
        tbl.push_back(mk(1, 0, 0, C_ALU,  1,  2,  5, 32'h11,       K_LOAD,             0,  1));
        tbl.push_back(mk(0, 0, 0, C_LW,   5,  5,  9, 32'hDEAD,     K_BUB,              0,  2));
        tbl.push_back(mk(1, 0, 0, C_LW,   2,  0,  7, 32'h100,      K_LOAD,             0,  3));
        tbl.push_back(mk(1, 0, 0, C_ALU,  7,  3,  8, 32'h33,       HZ ? K_BUB : K_LOAD, HZ, 4));
        tbl.push_back(mk(1, 0, 0, C_ALU,  7,  3,  8, 32'h33,       K_LOAD,             0,  4));
        tbl.push_back(mk(1, 0, 0, C_LW,   3,  0,  0, 32'h200,      K_LOAD,             0,  5));
        tbl.push_back(mk(1, 0, 0, C_ALU,  0,  0,  6, 32'h66,       K_LOAD,             0,  6));
        tbl.push_back(mk(1, 0, 0, C_LW,   6,  0,  9, 32'h300,      K_LOAD,             0,  7));
        tbl.push_back(mk(1, 0, 0, C_ADDI, 4,  9, 10, 32'h44,       HZ ? K_BUB : K_LOAD, HZ, 8));
        tbl.push_back(mk(1, 0, 0, C_ADDI, 4,  9, 10, 32'h44,       K_LOAD,             0,  8));
        tbl.push_back(mk(1, 0, 0, C_ALU,  1,  2, 10, 32'hA0,       K_LOAD,             0,  9));
        tbl.push_back(mk(1, 1, 0, C_ALU, 10,  3, 11, 32'hA1,       K_HOLD,             0, 10));
        tbl.push_back(mk(1, 1, 0, C_LW,  10, 10, 12, 32'hA2,       K_HOLD,             0, 11));
        tbl.push_back(mk(0, 1, 0, C_SW,   4,  4, 13, 32'hA3,       K_HOLD,             0, 12));
        tbl.push_back(mk(1, 0, 0, C_JAL, 10,  0, 14, 32'hA4,       K_LOAD,             0, 13));
        tbl.push_back(mk(1, 1, 1, C_BR,   1,  2,  0, 32'hB0,       K_BUB,              0, 14));
        tbl.push_back(mk(1, 0, 0, C_LW,   1,  0, 12, 32'hC0,       K_LOAD,             0, 15));
        tbl.push_back(mk(1, 0, 1, C_ALU,  3, 12, 15, 32'hC1,       K_BUB,              0, 16));
        tbl.push_back(mk(1, 0, 0, C_ALU, 12,  3, 16, 32'hC2,       K_LOAD,             0, 17));
        tbl.push_back(mk(1, 0, 0, C_LW,   1,  0, 13, 32'hD0,       K_LOAD,             0, 18));
        tbl.push_back(mk(0, 0, 0, C_ALU, 13,  2, 17, 32'hD1,       K_BUB,              0, 19));
        tbl.push_back(mk(1, 0, 0, C_LW,   1,  0, 14, 32'hE0,       K_LOAD,             0, 20));
        tbl.push_back(mk(1, 1, 0, C_ALU, 14,  2, 18, 32'hE1,       K_HOLD,             0, 21));
        tbl.push_back(mk(1, 0, 0, C_ALU, 14,  2, 18, 32'hE1,       HZ ? K_BUB : K_LOAD, HZ, 21));
        tbl.push_back(mk(1, 0, 0, C_ALU, 14,  2, 18, 32'hE1,       K_LOAD,             0, 21));
        tbl.push_back(mk(1, 0, 0, C_ALU,  1,  2,  5, 32'h55,       K_LOAD,             0, 22));

        // Reset state.
        #12;
        check("reset_out", dut_word(), '0);
        check("reset_hz", OW'(hazard_stall_o), '0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

        // Asynchronous reset mid-cycle while a regwrite instruction sits in EX.
        check("pre_rst_regwrite", OW'(ex_regwrite), OW'(1));
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_out", dut_word(), '0);
        check("async_rst_hz", OW'(hazard_stall_o), '0);
        @(negedge clk);
        rst_n = 1'b1;
        model_state = '0;

        // First instruction after reset must load cleanly; then a load-use pair.
        step(mk(1, 0, 0, C_LW,  1, 0, 7, 32'hF0, K_LOAD, 0, 23), "post_rst_lw");
        step(mk(1, 0, 0, C_ALU, 7, 2, 3, 32'hF1, HZ ? K_BUB : K_LOAD, HZ, 24), "post_rst_use");
        step(mk(1, 0, 0, C_ALU, 7, 2, 3, 32'hF1, K_LOAD, 0, 24), "post_rst_adv");

        check("sb_drained", OW'(exp_q.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

endmodule
